// File: rtl/universal_shift_burst_reg_if.sv
// Bus bundle for universal_shift_burst_reg.
// master drives load/start/mode/amount/serial_in; slave drives q/serial_out/busy/done.
interface universal_shift_burst_reg_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic [WIDTH-1:0] i;
  logic             load_enable;
  logic             start;
  logic [2:0]       mode;
  logic [AMT_W-1:0] amount;
  logic             serial_in;
  logic [WIDTH-1:0] q;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output i, load_enable, start, mode, amount, serial_in,
    input  q, serial_out, busy, done
  );

  modport slave (
    input  i, load_enable, start, mode, amount, serial_in,
    output q, serial_out, busy, done
  );
endinterface

// File: rtl/universal_shift_burst_reg.sv
// Universal shift register with parallel load and a start/busy/done shift burst.
// Ports: clk, reset (sync, active-high), bus (slave: i/load/start/mode/amount/serial_in -> q/serial_out/busy/done).
module universal_shift_burst_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic clk,
  input  logic reset,
  universal_shift_burst_reg_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);
  localparam logic [AMT_W-1:0] CNT_ZERO = '0;

  logic [0:0]       state;
  logic [WIDTH-1:0] q_r;
  logic             so_r;
  logic             busy_r;
  logic             done_r;
  logic [2:0]       mode_r;
  logic [AMT_W-1:0] cnt;

  logic [WIDTH-1:0] q_sh;
  logic             so_sh;

  logic is_sll;
  logic is_srl;
  logic is_rol;
  logic is_ror;
  logic is_asr;

  assign is_sll = (mode_r == 3'b000);
  assign is_srl = (mode_r == 3'b001);
  assign is_rol = (mode_r == 3'b010);
  assign is_ror = (mode_r == 3'b011);
  assign is_asr = (mode_r == 3'b100);

  // Single-bit step for the latched mode; reserved modes hold q and serial_out.
  always_comb begin
    q_sh  = q_r;
    so_sh = so_r;
    unique case (1'b1)
      is_sll: begin
        q_sh  = {q_r[WIDTH-2:0], bus.serial_in};
        so_sh = q_r[WIDTH-1];
      end
      is_srl: begin
        q_sh  = {bus.serial_in, q_r[WIDTH-1:1]};
        so_sh = q_r[0];
      end
      is_rol: begin
        q_sh  = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        so_sh = q_r[WIDTH-1];
      end
      is_ror: begin
        q_sh  = {q_r[0], q_r[WIDTH-1:1]};
        so_sh = q_r[0];
      end
      is_asr: begin
        q_sh  = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
        so_sh = q_r[0];
      end
      default: begin
        q_sh  = q_r;
        so_sh = so_r;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      q_r    <= '0;
      so_r   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      mode_r <= 3'b000;
      cnt    <= CNT_ZERO;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_enable) begin
            q_r <= bus.i;
          end else if (bus.start) begin
            // A zero-length burst completes immediately without going busy.
            if (bus.amount != CNT_ZERO) begin
              mode_r <= bus.mode;
              cnt    <= bus.amount;
              busy_r <= 1'b1;
              state  <= SHIFT;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        SHIFT: begin
          q_r  <= q_sh;
          so_r <= so_sh;
          cnt  <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.q          = q_r;
  assign bus.serial_out = so_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;

endmodule

// File: tb/tb_universal_shift_burst_reg.sv
// Bench for universal_shift_burst_reg: directed bursts plus random traffic.
// Outputs are compared every cycle against a behavioural model.
module tb_universal_shift_burst_reg;

  localparam int W  = 8;
  localparam int AW = 3;
  localparam int M  = (1 << W) - 1;

  logic clk;
  logic reset;

  universal_shift_burst_reg_if #(.WIDTH(W), .AMT_W(AW)) bus();

  universal_shift_burst_reg #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // Behavioural model: remaining-shift count plus integer register value.
  int m_q    = 0;
  int m_so   = 0;
  int m_busy = 0;
  int m_done = 0;
  int m_rem  = 0;
  int m_mode = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic step(input int md, input int q, input int si,
                      output int nq, output int o);
    nq = q;
    o  = m_so;
    case (md)
      0: begin nq = ((q << 1) | si) & M;            o = (q >> (W-1)) & 1; end
      1: begin nq = (q >> 1) | (si << (W-1));       o = q & 1;            end
      2: begin nq = ((q << 1) | (q >> (W-1))) & M;  o = (q >> (W-1)) & 1; end
      3: begin nq = (q >> 1) | ((q & 1) << (W-1));  o = q & 1;            end
      4: begin nq = (q >> 1) | (q & (1 << (W-1)));  o = q & 1;            end
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    int nq, o;
    if (reset) begin
      m_q = 0; m_so = 0; m_busy = 0; m_done = 0; m_rem = 0;
    end else begin
      m_done = 0;
      if (m_rem == 0) begin
        if (bus.load_enable) m_q = int'(bus.i);
        else if (bus.start) begin
          if (bus.amount != 0) begin
            m_rem  = int'(bus.amount);
            m_mode = int'(bus.mode);
            m_busy = 1;
          end else m_done = 1;
        end
      end else begin
        step(m_mode, m_q, int'(bus.serial_in), nq, o);
        m_q  = nq;
        m_so = o;
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("q", 32'(bus.q), 32'(m_q));
      chk("serial_out", 32'(bus.serial_out), 32'(m_so));
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("busy_and_done", 32'(bus.busy & bus.done), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_enable = 1'b0;
    bus.start       = 1'b0;
  endtask

  task automatic load(input logic [W-1:0] v);
    bus.i = v;
    bus.load_enable = 1'b1;
    tick();
    bus.load_enable = 1'b0;
  endtask

  // Starts a burst, disturbs mode/amount (and optionally loads) mid-burst,
  // and waits for done within a bounded number of cycles.
  task automatic burst(input logic [2:0] md, input logic [AW-1:0] amt,
                       input logic si, input bit ld_mid,
                       output int bc);
    bit ok;
    bus.mode = md;
    bus.amount = amt;
    bus.serial_in = si;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.mode = 3'b000;
    bus.amount = '1;
    if (ld_mid) begin
      bus.i = 8'hFF;
      bus.load_enable = 1'b1;
    end
    bc = 0;
    ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (bus.busy) bc++;
      if (bus.done) ok = 1;
      else tick();
    end
    bus.load_enable = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL burst_timeout: got no done want done");
    end
  endtask

  initial begin
    int bc;
    reset = 1'b1;
    bus.i = W'($urandom);
    bus.load_enable = 1'b1;
    bus.start = 1'b1;
    bus.mode = 3'($urandom);
    bus.amount = AW'($urandom);
    bus.serial_in = 1'b1;
    tick();
    tick();
    chk_en = 1;
    chk("rst_q", 32'(bus.q), 32'h00);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_so", 32'(bus.serial_out), 32'd0);
    reset = 1'b0;
    idle_inputs();

    load(8'hA8);
    burst(3'b000, 3'd3, 1'b0, 0, bc);
    chk("sll_busy_cycles", 32'(bc), 32'd3);
    chk("sll_q", 32'(bus.q), 32'h40);
    chk("sll_so", 32'(bus.serial_out), 32'd1);
    tick();
    chk("sll_done_1cyc", 32'(bus.done), 32'd0);

    load(8'hA5);
    burst(3'b011, 3'd4, 1'b0, 0, bc);
    chk("ror_busy_cycles", 32'(bc), 32'd4);
    chk("ror_q", 32'(bus.q), 32'h5A);
    chk("ror_so", 32'(bus.serial_out), 32'd0);
    tick();

    load(8'h90);
    burst(3'b100, 3'd2, 1'b0, 0, bc);
    chk("asr_q", 32'(bus.q), 32'hE4);
    chk("asr_so", 32'(bus.serial_out), 32'd0);
    tick();

    load(8'h90);
    burst(3'b001, 3'd2, 1'b1, 0, bc);
    chk("srl_q", 32'(bus.q), 32'hE4);
    chk("srl_so", 32'(bus.serial_out), 32'd0);
    tick();

    bus.amount = '0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("amt0_done", 32'(bus.done), 32'd1);
    chk("amt0_busy", 32'(bus.busy), 32'd0);
    chk("amt0_q", 32'(bus.q), 32'hE4);
    tick();
    chk("amt0_done_clr", 32'(bus.done), 32'd0);

    bus.i = 8'h3C;
    bus.amount = 3'd3;
    bus.load_enable = 1'b1;
    bus.start = 1'b1;
    tick();
    idle_inputs();
    chk("ld_st_q", 32'(bus.q), 32'h3C);
    chk("ld_st_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("ld_st_done", 32'(bus.done), 32'd0);

    burst(3'b010, 3'd2, 1'b1, 1, bc);
    chk("rol_ldmid_q", 32'(bus.q), 32'hF0);
    chk("rol_ldmid_so", 32'(bus.serial_out), 32'd0);
    tick();

    load(8'h01);
    bus.mode = 3'b010;
    bus.amount = 3'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("rol3_q", 32'(bus.q), 32'h08);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_q", 32'(bus.q), 32'h00);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    tick();
    chk("abort_no_done", 32'(bus.done), 32'd0);
    burst(3'b000, 3'd1, 1'b1, 0, bc);
    chk("post_rst_q", 32'(bus.q), 32'h01);
    chk("post_rst_bc", 32'(bc), 32'd1);
    tick();

    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      bus.load_enable = ($urandom_range(0, 7) == 0);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.mode = 3'($urandom);
      bus.amount = AW'($urandom);
      bus.serial_in = 1'($urandom);
      bus.i = W'($urandom);
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
